// File: rtl/lcd_stream_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_stream_writer                                                          |
// | HD44780-class LCD writer: power-up/init script, then drains a {rs,byte}    |
// | FIFO over an 8-bit or 4-bit bus with programmable E/settle timing.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lcd_stream_writer #(
    parameter int BUS_MODE     = 8,
    parameter int E_PULSE_CYC  = 25,
    parameter int SETUP_CYC    = 2,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000,
    parameter int POWERUP_CYC  = 750000,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_rs,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic [7:0]                  lcd_data,
    output logic                        lcd_rs,
    output logic                        lcd_rw,
    output logic                        lcd_e,
    output logic                        init_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int c_aw   = $clog2(FIFO_DEPTH);
    localparam int c_m1   = (E_PULSE_CYC > SETUP_CYC) ? E_PULSE_CYC : SETUP_CYC;
    localparam int c_m2   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
    localparam int c_m3   = (c_m1 > c_m2) ? c_m1 : c_m2;
    localparam int c_max  = (c_m3 > POWERUP_CYC) ? c_m3 : POWERUP_CYC;
    localparam int c_cw   = $clog2(c_max + 1);

    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [c_cw-1:0] c_pwr_last = c_cw'(POWERUP_CYC - 1);
    localparam logic [c_cw-1:0] c_su_last  = c_cw'(SETUP_CYC - 1);
    localparam logic [c_cw-1:0] c_e_last   = c_cw'(E_PULSE_CYC - 1);
    localparam logic [c_cw-1:0] c_cmd_last = c_cw'(CMD_WAIT_CYC - 1);
    localparam logic [c_cw-1:0] c_clr_last = c_cw'(CLR_WAIT_CYC - 1);
    localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
    localparam logic [c_aw:0]   c_lvl_one  = (c_aw + 1)'(1);
    localparam logic [c_aw:0]   c_full     = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [2:0]      c_init_last = (BUS_MODE == 4) ? 3'd4 : 3'd3;

    generate
        if (E_PULSE_CYC < 1 || SETUP_CYC < 1 || CMD_WAIT_CYC < 1 ||
            CLR_WAIT_CYC < 1 || POWERUP_CYC < 1) begin : g_bad_timing
            $error("lcd_stream_writer: timing parameters must be >= 1");
        end
        if (BUS_MODE != 4 && BUS_MODE != 8) begin : g_bad_bus
            $error("lcd_stream_writer: BUS_MODE must be 4 or 8");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("lcd_stream_writer: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_POWERUP = 3'd0,
        S_IDLE    = 3'd1,
        S_SETUP   = 3'd2,
        S_EHIGH   = 3'd3,
        S_SETUP2  = 3'd4,
        S_EHIGH2  = 3'd5,
        S_SETTLE  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic [2:0]      step_q, step_d;
    logic [7:0]      byte_q, byte_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            lone_q, lone_d;
    logic            init_done_q, init_done_d;
    logic            lcd_e_q, busy_q, in_ready_q;

    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [c_aw-1:0] wr_q, rd_q;
    logic [c_aw:0]   count_q, count_d;
    logic            push, pop;
    logic [8:0]      head;
    logic [c_cw-1:0] settle_last;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        if (BUS_MODE == 4) begin
            case (idx)
                3'd0:    b = 8'h20;  // lone high nibble selecting 4-bit mode
                3'd1:    b = 8'h28;
                3'd2:    b = 8'h0C;
                3'd3:    b = 8'h01;
                default: b = 8'h06;
            endcase
        end else begin
            case (idx)
                3'd0:    b = 8'h38;
                3'd1:    b = 8'h0C;
                3'd2:    b = 8'h01;
                default: b = 8'h06;
            endcase
        end
        return b;
    endfunction

    function automatic logic [7:0] bus_hi(input logic [7:0] b);
        return (BUS_MODE == 4) ? {b[7:4], 4'h0} : b;
    endfunction

    assign push        = in_valid && in_ready_q;
    assign head        = mem_q[rd_q];
    assign settle_last = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ? c_clr_last : c_cmd_last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + c_cnt_one;
        step_d      = step_q;
        byte_d      = byte_q;
        data_d      = data_q;
        rs_d        = rs_q;
        lone_d      = lone_q;
        init_done_d = init_done_q;
        pop         = 1'b0;
        case (state_q)
            S_POWERUP: begin
                if (cnt_q == c_pwr_last) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    step_d  = 3'd0;
                    byte_d  = init_byte(3'd0);
                    data_d  = bus_hi(init_byte(3'd0));
                    rs_d    = 1'b0;
                    lone_d  = (BUS_MODE == 4);
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                    byte_d  = head[7:0];
                    rs_d    = head[8];
                    data_d  = bus_hi(head[7:0]);
                    lone_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == c_su_last) begin
                    state_d = S_EHIGH;
                    cnt_d   = '0;
                end
            end
            S_EHIGH: begin
                if (cnt_q == c_e_last) begin
                    cnt_d = '0;
                    if (BUS_MODE == 4 && !lone_q) begin
                        state_d = S_SETUP2;
                        data_d  = {byte_q[3:0], 4'h0};
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETUP2: begin
                if (cnt_q == c_su_last) begin
                    state_d = S_EHIGH2;
                    cnt_d   = '0;
                end
            end
            S_EHIGH2: begin
                if (cnt_q == c_e_last) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == settle_last) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (step_q == c_init_last) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = S_SETUP;
                        byte_d  = init_byte(step_q + 3'd1);
                        data_d  = bus_hi(init_byte(step_q + 3'd1));
                        lone_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_POWERUP;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + c_lvl_one;
        end else if (pop && !push) begin
            count_d = count_q - c_lvl_one;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {in_rs, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_POWERUP;
            cnt_q       <= '0;
            step_q      <= '0;
            byte_q      <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            lone_q      <= 1'b0;
            init_done_q <= 1'b0;
            lcd_e_q     <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            byte_q      <= byte_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            lone_q      <= lone_d;
            init_done_q <= init_done_d;
            lcd_e_q     <= (state_d == S_EHIGH) || (state_d == S_EHIGH2);
            busy_q      <= (state_d != S_IDLE) || (count_d != '0);
            // Room freed by a pop only shows up on the following cycle.
            in_ready_q  <= (count_d != c_full);
            count_q     <= count_d;
            if (push) begin
                wr_q <= wr_q + c_ptr_one;
            end
            if (pop) begin
                rd_q <= rd_q + c_ptr_one;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = lcd_e_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;
    assign fifo_level = count_q;
endmodule
`default_nettype wire

// File: tb/tb_lcd_stream_writer.sv
`default_nettype none
// Scoreboard bench: an 8-bit writer fed with directed and random bursts, plus a
// 4-bit writer whose init nibble stream is compared against the command script.
module tb_lcd_stream_writer;
    localparam int E_P   = 3;
    localparam int SU    = 2;
    localparam int CMDW  = 5;
    localparam int CLRW  = 20;
    localparam int PWR   = 10;
    localparam int DEPTH = 4;
    localparam int K_NONE = 0;
    localparam int K_RISE = 1;
    localparam int K_BUSY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, lcd_rs, lcd_rw, lcd_e, init_done, busy;
    logic [7:0] lcd_data;
    logic [2:0] fifo_level;

    logic       zero1 = 1'b0;
    logic [7:0] zero8 = 8'h00;
    logic       in_ready4, lcd_rs4, lcd_rw4, lcd_e4, init_done4, busy4;
    logic [7:0] lcd_data4;
    logic [2:0] fifo_level4;

    always #5 clk = ~clk;

    lcd_stream_writer #(
        .BUS_MODE(8), .E_PULSE_CYC(E_P), .SETUP_CYC(SU), .CMD_WAIT_CYC(CMDW),
        .CLR_WAIT_CYC(CLRW), .POWERUP_CYC(PWR), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
        .in_ready(in_ready), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .init_done(init_done), .busy(busy), .fifo_level(fifo_level)
    );

    lcd_stream_writer #(
        .BUS_MODE(4), .E_PULSE_CYC(E_P), .SETUP_CYC(SU), .CMD_WAIT_CYC(CMDW),
        .CLR_WAIT_CYC(CLRW), .POWERUP_CYC(PWR), .FIFO_DEPTH(DEPTH)
    ) dut4 (
        .clk(clk), .rst(rst), .in_valid(zero1), .in_rs(zero1), .in_data(zero8),
        .in_ready(in_ready4), .lcd_data(lcd_data4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4),
        .lcd_e(lcd_e4), .init_done(init_done4), .busy(busy4), .fifo_level(fifo_level4)
    );

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
        logic       init;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // HD44780 rule: clear (0x01) and home (0x02) commands need the long settle.
    function automatic int wait_of(input exp_t e);
        return (!e.rs && (e.d == 8'h01 || e.d == 8'h02)) ? CLRW : CMDW;
    endfunction

    // ---------------- 8-bit monitor / scoreboard ----------------
    int   cyc = 0, ref_t = 0, fall_t = 0, rise_t = 0, last_wait = 0;
    int   pend_kind = K_NONE, pend_gap = 0;
    logic e_prev = 1'b0, busy_prev = 1'b0, idone_prev = 1'b0;
    exp_t cur = '0;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                exp_q.delete();
                pend_kind  = K_RISE;
                pend_gap   = PWR + SU;
                ref_t      = cyc;
                e_prev     = 1'b0;
                busy_prev  = 1'b0;
                idone_prev = 1'b0;
            end else begin
                if (lcd_e && !e_prev) begin
                    if (pend_kind != K_NONE)
                        chk("gap before E rise", (pend_kind == K_RISE) ? cyc - ref_t : -1, pend_gap);
                    pend_kind = K_NONE;
                    if (exp_q.size() == 0) begin
                        chk("unexpected transfer", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("lcd_data", int'(lcd_data), int'(cur.d));
                        chk("lcd_rs", int'(lcd_rs), int'(cur.rs));
                    end
                    rise_t = cyc;
                end
                if (!lcd_e && e_prev) begin
                    chk("E pulse width", cyc - rise_t, E_P);
                    last_wait = wait_of(cur);
                    fall_t    = cyc;
                    ref_t     = cyc;
                    if (exp_q.size() != 0) begin
                        pend_kind = K_RISE;
                        pend_gap  = last_wait + SU + (exp_q[0].init ? 0 : 1);
                    end else begin
                        pend_kind = K_BUSY;
                        pend_gap  = last_wait;
                    end
                end
                if (!busy && busy_prev) begin
                    chk("busy fall time", (pend_kind == K_BUSY) ? cyc - ref_t : -1, pend_gap);
                    pend_kind = K_NONE;
                end
                if (init_done && !idone_prev)
                    chk("init_done rise time", cyc - fall_t, last_wait);
                e_prev     = lcd_e;
                busy_prev  = busy;
                idone_prev = init_done;
            end
        end
    end

    // ---------------- 4-bit init nibble monitor ----------------
    int         n4 = 0;
    bit         low_bad = 1'b0;
    bit         rw_bad = 1'b0;
    logic       e4_prev = 1'b0;
    logic [3:0] nib_exp [9] = '{4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

    initial begin : monitor4
        forever begin
            @(posedge clk);
            #1;
            if (lcd_data4[3:0] != 4'h0) low_bad = 1'b1;
            if (lcd_rw || lcd_rw4) rw_bad = 1'b1;
            if (lcd_e4 && !e4_prev && n4 < 9) begin
                chk("4-bit init nibble", int'(lcd_data4[7:4]), int'(nib_exp[n4]));
                chk("4-bit init rs", int'(lcd_rs4), 0);
                n4++;
            end
            e4_prev = lcd_e4;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_init;
        exp_q.push_back('{rs: 1'b0, d: 8'h38, init: 1'b1});
        exp_q.push_back('{rs: 1'b0, d: 8'h0C, init: 1'b1});
        exp_q.push_back('{rs: 1'b0, d: 8'h01, init: 1'b1});
        exp_q.push_back('{rs: 1'b0, d: 8'h06, init: 1'b1});
    endtask

    task automatic do_reset(input bit now);
        if (!now) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset lcd_e", int'(lcd_e), 0);
        chk("reset fifo_level", int'(fifo_level), 0);
        chk("reset init_done", int'(init_done), 0);
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset lcd_data", int'(lcd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        push_init();
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_rs    = rs;
            in_data  = d;
            acc      = in_ready;
            if (acc) exp_q.push_back('{rs: rs, d: d, init: 1'b0});
        end
        if (!acc) chk("push accepted", 0, 1);
    endtask

    task automatic end_burst;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < budget);
        chk(name, int'(busy) + exp_q.size(), 0);
    endtask

    initial begin : driver
        int         acc_n;
        int         nb;
        logic       rs;
        logic [7:0] d;

        do_reset(1'b0);

        // Fill the FIFO during power-up with valid held high.
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_rs    = 1'b1;
            in_data  = 8'($urandom);
            if (in_ready) begin
                acc_n++;
                exp_q.push_back('{rs: 1'b1, d: in_data, init: 1'b0});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("entries accepted when full", acc_n, DEPTH);
        chk("in_ready when full", int'(in_ready), 0);
        chk("fifo_level when full", int'(fifo_level), DEPTH);
        wait_idle(3000, "drain after init");
        chk("init_done after init", int'(init_done), 1);

        send(1'b1, 8'h48);
        send(1'b1, 8'h69);
        end_burst();
        wait_idle(500, "stream idle");

        for (int b = 0; b < 8; b++) begin
            nb = int'($urandom_range(1, 4));
            for (int k = 0; k < nb; k++) begin
                rs = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       d = 8'h01;
                    1:       d = 8'h02;
                    default: d = 8'($urandom);
                endcase
                send(rs, d);
            end
            end_burst();
            wait_idle(1000, "random burst idle");
        end

        send(1'b0, 8'h01);
        send(1'b1, 8'h41);
        end_burst();
        wait_idle(500, "clear burst idle");
        send(1'b1, 8'h01);
        send(1'b1, 8'h41);
        end_burst();
        wait_idle(500, "data 0x01 burst idle");

        // Abort a transfer while E is high.
        send(1'b1, 8'($urandom));
        send(1'b1, 8'($urandom));
        send(1'b1, 8'($urandom));
        end_burst();
        acc_n = 0;
        while (!lcd_e && acc_n < 100) begin
            @(negedge clk);
            acc_n++;
        end
        chk("E high before mid-transfer reset", int'(lcd_e), 1);
        do_reset(1'b1);
        wait_idle(3000, "re-init after reset");
        chk("init_done after re-init", int'(init_done), 1);

        repeat (200) @(negedge clk);
        chk("4-bit nibble count", n4, 9);
        chk("4-bit low nibble always zero", int'(low_bad), 0);
        chk("lcd_rw always zero", int'(rw_bad), 0);
        chk("4-bit init_done", int'(init_done4), 1);
        chk("scoreboard empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lcd_stream_writer.md
Name: lcd_stream_writer

Overview:
- Parametrised successor to the fixed-script LCD init block: a generic HD44780-class character-LCD writer.
- Runs a built-in power-up/init sequence, then drains a FIFO of {rs, byte} entries pushed by any upstream (CPU display driver, debug printer) through a valid/ready handshake.
- Supports 8-bit or 4-bit bus modes and programmable E-pulse/settle timing.
- Replaces hand-coded per-message case tables in display paths.

Parameters:
- BUS_MODE, 8: LCD bus width, 8 or 4; in 4-bit mode only lcd_data[7:4] carries nibbles.
- E_PULSE_CYC, 25: cycles lcd_e is held high per transfer (≥1).
- SETUP_CYC, 2: cycles data/rs are stable with E low before E rises (≥1).
- CMD_WAIT_CYC, 2500: settle cycles after every byte except clear/home.
- CLR_WAIT_CYC, 100000: settle cycles after a command (rs=0) byte 0x01 or 0x02.
- POWERUP_CYC, 750000: wait after reset before the first init transfer.
- FIFO_DEPTH, 16: entries in the input FIFO (power of two, ≥2).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: upstream entry valid.
- in_rs, input, 1: 0 = command, 1 = character data.
- in_data, input, 8: byte to write.
- in_ready, output, 1: FIFO can accept; equals !full.
- lcd_data, output, 8: LCD data bus.
- lcd_rs, output, 1: register select.
- lcd_rw, output, 1: constant 0 (write only).
- lcd_e, output, 1: enable strobe.
- init_done, output, 1: high once the init sequence completes; stays high until rst.
- busy, output, 1: high when in any state other than IDLE, or when the FIFO is non-empty.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (rst high at a clk edge): all outputs 0 (in_ready 0 while rst is high), FIFO emptied, state POWERUP, all counters cleared. Reset mid-transfer aborts immediately and lcd_e drops on that edge.
- Handshake: a push occurs on an edge where in_valid && in_ready.
  - Pushes are accepted during POWERUP and INIT; entries are held until init_done.
  - in_ready is registered from the full flag. When full, in_ready=0 and input is ignored.
  - A pop in the same cycle does not make room until the next cycle.
- FIFO: circular with wrap-around pointers. Occupancy changes +1 on push only, -1 on pop only, and is unchanged on push+pop in the same cycle.
- State machine: POWERUP → INIT → IDLE ↔ XFER.
  - POWERUP counts POWERUP_CYC cycles, then enters INIT.
  - INIT sends the fixed script through the same transfer engine, all with rs=0.
    - 8-bit mode: 0x38, 0x0C, 0x01, 0x06.
    - 4-bit mode: one lone high nibble 0x2 (a single E pulse, followed by CMD_WAIT_CYC), then 0x28, 0x0C, 0x01, 0x06.
  - After the last settle period, init_done rises and the block enters IDLE.
  - IDLE: if the FIFO is non-empty, pop the head (one cycle) and enter XFER; otherwise stay. lcd_e=0 and the bus holds the last value.
- Transfer engine, per byte:
  - SETUP: drive lcd_rs and lcd_data for SETUP_CYC cycles with E=0.
  - EHIGH: E=1 for E_PULSE_CYC cycles.
  - 4-bit mode only: after the high-nibble pulse, hold E low for SETUP_CYC cycles, place the low nibble on [7:4], then pulse E again for E_PULSE_CYC. lcd_data[3:0]=0 throughout in 4-bit mode.
  - SETTLE: E=0 for CMD_WAIT_CYC cycles, or CLR_WAIT_CYC if rs=0 and byte ∈ {0x01, 0x02}.
  - Then return to IDLE, or to the next init step.
  - Data and rs stay stable for the entire transfer, including SETTLE.
- 8-bit total cycles per byte = 1 (pop) + SETUP_CYC + E_PULSE_CYC + wait.
- Back-to-back FIFO entries are serviced with no extra idle cycle beyond the pop cycle.
- Counter width is sized for the maximum of all timing parameters. A value of 0 for any timing parameter is illegal; flag it with an elaboration-time check.

Test Plan:
Use small timing values for every test: E_PULSE_CYC=3, SETUP_CYC=2, CMD_WAIT_CYC=5, CLR_WAIT_CYC=20, POWERUP_CYC=10.

- Init, 8-bit: release rst → E first rises 12 cycles later with data 0x38 and rs=0. Four E pulses occur, in order 0x38/0x0C/0x01/0x06, each 3 cycles wide. The gap after 0x01 is 20 cycles. init_done rises after the 0x06 settle.
- Init, 4-bit (BUS_MODE=4): lcd_data[7:4] nibble sequence is 2, 2,8, 0,C, 0,1, 0,6. lcd_data[3:0] is always 0.
- Stream: push rs=1 bytes 0x48, 0x69 → two transfers, each 1+2+3+5=11 cycles, with lcd_rs=1 and correct bytes. busy falls after the second settle.
- Full FIFO (FIFO_DEPTH=4): push 6 entries during POWERUP with in_valid held → exactly 4 accepted, in_ready=0, fifo_level=4. All 4 bytes are emitted in order after init.
- Clear timing: push rs=0 0x01, then rs=1 0x41 → gap between the E pulses is 20 settle cycles, not 5. Pushing rs=1 0x01 gets only 5 cycles.
- Reset mid-transfer: assert rst while E is high → the next edge gives lcd_e=0, fifo_level=0, init_done=0, and the init sequence restarts.
